// File: rtl/keypad_scan_controller_if.sv
// Keypad pin and key-report bundle; master is the scan controller, slave is the pad/consumer side.
interface keypad_scan_controller_if;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  cols,
        output rows,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output cols,
        input  rows,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: one-cold row drive, 2-flop column sync, debounced press/release, one strobe per key.
// key_valid lands DEBOUNCE_CYCLES+1 cycles after detection; all outputs registered, no backpressure.
module keypad_scan_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    keypad_scan_controller_if.master   kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, n_state;
    logic [1:0]    r, n_r;
    logic [DW-1:0] dwell, n_dwell;
    logic [BW-1:0] deb, n_deb;
    logic [3:0]    cap, n_cap;
    logic [3:0]    key, n_key;
    logic          key_valid, n_key_valid;
    logic          key_held, n_key_held;
    logic [3:0]    rows, n_rows;
    logic [3:0]    sync1, scols;
    logic [1:0]    low_col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 4'hF;
            scols     <= 4'hF;
            state     <= SCAN;
            r         <= 2'd0;
            dwell     <= '0;
            deb       <= '0;
            cap       <= 4'hF;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            rows      <= 4'b1110;
        end else begin
            sync1     <= kp.cols;
            scols     <= sync1;
            state     <= n_state;
            r         <= n_r;
            dwell     <= n_dwell;
            deb       <= n_deb;
            cap       <= n_cap;
            key       <= n_key;
            key_valid <= n_key_valid;
            key_held  <= n_key_held;
            rows      <= n_rows;
        end
    end

    // Multi-column presses report the lowest pressed column.
    always_comb begin
        low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cap[i]) low_col = 2'(i);
        end
    end

    always_comb begin
        n_state     = state;
        n_r         = r;
        n_dwell     = dwell;
        n_deb       = deb;
        n_cap       = cap;
        n_key       = key;
        n_key_valid = 1'b0;
        n_key_held  = key_held;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    if (scols == 4'hF) begin
                        n_dwell = '0;
                        n_r     = r + 2'd1;
                    end else begin
                        n_cap   = scols;
                        n_deb   = '0;
                        n_state = DEBOUNCE;
                    end
                end else begin
                    n_dwell = dwell + DW'(1);
                end
            end
            DEBOUNCE: begin
                // A bounce moves on to the next row rather than retrying this one.
                if (scols != cap) begin
                    n_state = SCAN;
                    n_r     = r + 2'd1;
                    n_dwell = '0;
                end else if (deb != DEB_LAST) begin
                    n_deb = deb + BW'(1);
                end else begin
                    n_state     = HELD;
                    n_key       = {r, low_col};
                    n_key_valid = 1'b1;
                    n_key_held  = 1'b1;
                end
            end
            HELD: begin
                if (scols == 4'hF) begin
                    n_deb   = '0;
                    n_state = RELEASE;
                end
            end
            RELEASE: begin
                if (scols != 4'hF) begin
                    n_state = HELD;
                end else if (deb != DEB_LAST) begin
                    n_deb = deb + BW'(1);
                end else begin
                    n_state    = SCAN;
                    n_key_held = 1'b0;
                    n_r        = r + 2'd1;
                    n_dwell    = '0;
                end
            end
            default: n_state = SCAN;
        endcase
        n_rows = ~(4'b0001 << n_r);
    end

    assign kp.rows      = rows;
    assign kp.key       = key;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;
endmodule

// File: tb/tb_keypad_scan_controller.sv
// Directed bench: a keypad model drives cols from rows; expected timings are hand-derived.
module tb_keypad_scan_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       press_en;
    logic [1:0] prow;
    logic [3:0] pcols;
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;

    keypad_scan_controller_if kif();

    keypad_scan_controller #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        kif.cols = 4'hF;
        if (press_en && kif.rows[prow] == 1'b0) kif.cols = pcols;
    end

    always @(posedge clk) begin
        if (kif.key_valid === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rows(input logic [3:0] target);
        int n = 0;
        while (kif.rows !== target && n < 40) begin
            tick;
            n++;
        end
        check("wait_rows", 32'(kif.rows), 32'(target));
    endtask

    initial begin
        reset    = 1'b0;
        press_en = 1'b0;
        prow     = 2'd0;
        pcols    = 4'hF;

        // Reset and idle scan
        repeat (3) tick;
        check("rst_rows", 32'(kif.rows), 32'h0000_000E);
        check("rst_key", 32'(kif.key), 32'h0);
        check("rst_valid", 32'(kif.key_valid), 32'h0);
        check("rst_held", 32'(kif.key_held), 32'h0);
        #2 reset = 1'b1;
        repeat (3) tick;
        check("idle_r0", 32'(kif.rows), 32'h0000_000E);
        tick;
        check("idle_r1", 32'(kif.rows), 32'h0000_000D);
        repeat (4) tick;
        check("idle_r2", 32'(kif.rows), 32'h0000_000B);
        repeat (4) tick;
        check("idle_r3", 32'(kif.rows), 32'h0000_0007);
        repeat (4) tick;
        check("idle_wrap", 32'(kif.rows), 32'h0000_000E);
        check("idle_valid", 32'(kif.key_valid), 32'h0);
        check("idle_held", 32'(kif.key_held), 32'h0);

        // Clean press of row 2, col 1
        prow = 2'd2; pcols = 4'b1101; press_en = 1'b1;
        wait_rows(4'b1011);
        repeat (7) tick;
        check("press_early", 32'(kif.key_valid), 32'h0);
        tick;
        check("press_valid", 32'(kif.key_valid), 32'h1);
        check("press_key", 32'(kif.key), 32'h9);
        check("press_held", 32'(kif.key_held), 32'h1);
        check("press_rows", 32'(kif.rows), 32'h0000_000B);
        tick;
        check("press_pulse_end", 32'(kif.key_valid), 32'h0);
        repeat (30) tick;
        check("hold_rows", 32'(kif.rows), 32'h0000_000B);
        check("hold_held", 32'(kif.key_held), 32'h1);
        check("hold_pulses", 32'(pulses), 32'h1);
        press_en = 1'b0;
        repeat (6) tick;
        check("rel_still_held", 32'(kif.key_held), 32'h1);
        tick;
        check("rel_held_low", 32'(kif.key_held), 32'h0);
        check("rel_rows", 32'(kif.rows), 32'h0000_0007);

        // Press bounce on row 1, col 0
        prow = 2'd1; pcols = 4'b1110; press_en = 1'b1;
        wait_rows(4'b1101);
        repeat (5) tick;
        press_en = 1'b0;
        repeat (2) tick;
        check("bounce_frozen", 32'(kif.rows), 32'h0000_000D);
        tick;
        check("bounce_next_row", 32'(kif.rows), 32'h0000_000B);
        check("bounce_valid", 32'(kif.key_valid), 32'h0);
        check("bounce_held", 32'(kif.key_held), 32'h0);
        check("bounce_pulses", 32'(pulses), 32'h1);

        // Multi-column press on row 0
        prow = 2'd0; pcols = 4'b0110; press_en = 1'b1;
        wait_rows(4'b1110);
        repeat (8) tick;
        check("multi_valid", 32'(kif.key_valid), 32'h1);
        check("multi_key", 32'(kif.key), 32'h0);
        check("multi_held", 32'(kif.key_held), 32'h1);
        tick;
        check("multi_pulses", 32'(pulses), 32'h2);
        press_en = 1'b0;
        repeat (6) tick;
        check("multi_rel_held", 32'(kif.key_held), 32'h1);
        tick;
        check("multi_rel_low", 32'(kif.key_held), 32'h0);
        check("multi_rel_rows", 32'(kif.rows), 32'h0000_000D);

        // Release bounce on key F
        prow = 2'd3; pcols = 4'b0111; press_en = 1'b1;
        wait_rows(4'b0111);
        repeat (8) tick;
        check("f_valid", 32'(kif.key_valid), 32'h1);
        check("f_key", 32'(kif.key), 32'hF);
        repeat (5) tick;
        press_en = 1'b0;
        repeat (2) tick;
        press_en = 1'b1;
        repeat (10) tick;
        check("rbounce_held", 32'(kif.key_held), 32'h1);
        check("rbounce_rows", 32'(kif.rows), 32'h0000_0007);
        check("rbounce_pulses", 32'(pulses), 32'h3);
        press_en = 1'b0;
        repeat (6) tick;
        check("rfinal_still_held", 32'(kif.key_held), 32'h1);
        tick;
        check("rfinal_low", 32'(kif.key_held), 32'h0);
        check("rfinal_rows", 32'(kif.rows), 32'h0000_000E);
        check("rfinal_pulses", 32'(pulses), 32'h3);

        // Async reset while holding row 1, col 2
        prow = 2'd1; pcols = 4'b1011; press_en = 1'b1;
        wait_rows(4'b1101);
        repeat (8) tick;
        check("k6_valid", 32'(kif.key_valid), 32'h1);
        check("k6_key", 32'(kif.key), 32'h6);
        repeat (3) tick;
        check("k6_held", 32'(kif.key_held), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst_rows", 32'(kif.rows), 32'h0000_000E);
        check("arst_key", 32'(kif.key), 32'h0);
        check("arst_held", 32'(kif.key_held), 32'h0);
        check("arst_valid", 32'(kif.key_valid), 32'h0);
        repeat (2) tick;
        #2 reset = 1'b1;
        repeat (11) tick;
        check("post_rst_no_valid", 32'(kif.key_valid), 32'h0);
        check("post_rst_pulses", 32'(pulses), 32'h4);
        check("post_rst_held", 32'(kif.key_held), 32'h0);
        tick;
        check("post_rst_valid", 32'(kif.key_valid), 32'h1);
        check("post_rst_key", 32'(kif.key), 32'h6);
        press_en = 1'b0;
        repeat (10) tick;
        check("end_held", 32'(kif.key_held), 32'h0);
        check("end_pulses", 32'(pulses), 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequences scanning of a 4x4 matrix keypad. It drives the active-low row lines one at a time and samples the synchronized column lines. It debounces the press and release of one key and reports a single registered key-code strobe per debounced press. It sits between the keypad pins and the display/input logic, and replaces free-running row scanning with a state machine that freezes the scan while a key is held.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press or a release (legal range ≥ 2; silicon builds override it, for example 50000).
- SCAN_DIV, default 4: clock cycles each row is driven during scanning (legal range ≥ 3, which covers the synchronizer latency).
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low; 0 forces every register to its reset value immediately.
- cols, input, 4: raw column lines, active-low (0 = pressed in the driven row). Asynchronous.
- rows, output, 4: row drive, active-low one-cold; bit r = 0 drives row r.
- key, output, 4: code of the last accepted key, equal to 4*row + col. Holds its value until the next accept.
- key_valid, output, 1: one-cycle pulse when a press is accepted.
- key_held, output, 1: high from accept until the release is accepted.

## Operation
- cols passes through a 2-flop synchronizer (reset value 4'b1111) to give scols.
- The block keeps a row index r (2 bits), a dwell counter (0..SCAN_DIV-1), a debounce counter (0..DEBOUNCE_CYCLES-1), and a captured pattern cap[3:0].
- rows = ~(4'b0001 << r) at all times.
- States and transitions:
  - SCAN: the dwell counter increments each cycle.
    - At dwell = SCAN_DIV-1 with scols = 4'b1111: dwell←0 and r←r+1 (3 wraps to 0).
    - At dwell = SCAN_DIV-1 with scols ≠ 4'b1111: cap←scols, debounce←0, go to DEBOUNCE. r stays frozen.
    - scols is ignored at all other dwell values.
  - DEBOUNCE: each cycle compares scols to cap.
    - On a mismatch: go to SCAN with r←r+1 and dwell←0.
    - On a match with debounce < DEBOUNCE_CYCLES-1: debounce++.
    - On a match with debounce = DEBOUNCE_CYCLES-1: go to HELD, key←{r, c} where c is the lowest index with cap[c]=0, key_valid←1, key_held←1.
  - HELD: if scols = 4'b1111, debounce←0 and go to RELEASE. Any other pattern, including added or changed columns, is ignored.
  - RELEASE:
    - If scols ≠ 4'b1111: return to HELD, with no new key_valid.
    - If scols = 4'b1111 and debounce < DEBOUNCE_CYCLES-1: debounce++.
    - If scols = 4'b1111 and debounce = DEBOUNCE_CYCLES-1: go to SCAN, key_held←0, r←r+1, dwell←0.
- Only one key is reported at a time. Presses in other rows are invisible while r is frozen.

## Timing
- Reset values: rows=4'b1110 (r=0), key=4'h0, key_valid=0, key_held=0, state SCAN, all counters 0.
- Every output is registered; there are no combinational paths from cols to any output.
- Scan period is 4*SCAN_DIV cycles. With no key pressed, rows changes on every SCAN_DIV-th rising edge after reset deasserts.
- Press latency:
  - Call E0 the edge entering DEBOUNCE.
  - With a stable press, key_valid is high in the cycle after edge E0+DEBOUNCE_CYCLES, for exactly 1 cycle.
  - key and key_held update on that same edge.
- Release latency:
  - Call R0 the edge entering RELEASE.
  - key_held falls at edge R0+DEBOUNCE_CYCLES, and rows advances on the same edge.
- Boundaries:
  - A bounce during DEBOUNCE restarts scanning at the next row, not the same row.
  - A bounce during RELEASE keeps the key held.
  - key_valid never fires twice for a single held key.
- Reset asserted mid-operation returns all outputs to their reset values immediately. No key_valid is emitted after reset deasserts unless a new full debounce completes.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SCAN_DIV=4. The bench keypad model drives cols combinationally from rows.
- Reset and idle: hold reset=0, then release with no key pressed -> rows=1110 during reset, then steps 1101, 1011, 0111, 1110 every 4 cycles; key=0, key_valid=0, key_held=0.
- Clean press and release:
  - Stimulus: press row 2, col 1 (cols=1101 while rows=1011) for 40 cycles, then release.
  - Press response: exactly one key_valid pulse with key=4'h9, and key_held=1 with rows frozen at 1011.
  - Release response: key_held falls 4 edges after entry to RELEASE, and scanning resumes at rows=0111.
- Press bounce: press row 1, col 0 for only 2 cycles after detection -> no key_valid, key_held stays 0, scan continues at rows=1011.
- Multi-column press: row 0 with cols=0110 (cols 0 and 3) held -> key=4'h0, one pulse.
- Release bounce: while key 4'hF is held, release for 2 cycles, re-press, then release for good -> no second key_valid, key_held stays 1 until the final 4-cycle release completes.
- Async reset mid-operation: assert reset between clock edges while in HELD -> rows=1110, key=0, key_held=0 without waiting for a clock edge. After release of reset, a fresh 4-cycle debounce is required before the next pulse.
